// File: rtl/aes_round_ctrl_pkg.sv
// Shared types, constants and helpers for the AES round sequencer.
package aes_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_HOLD  = 2'd3
  } aes_ctrl_state_t;

  localparam int unsigned NR_AES128 = 10;
  localparam int unsigned NR_AES192 = 12;
  localparam int unsigned NR_AES256 = 14;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // GF(2^8) multiply by x with the AES reduction polynomial.
  function automatic logic [7:0] xtime8(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: loads 0x01, steps by xtime, clears to zero.
module aes_rcon_gen
  import aes_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       advance,
  input  logic       clear,
  output logic [7:0] rcon
);

  logic [7:0] rcon_q;
  logic [7:0] rcon_d;

  // Next rcon: clear beats init, init beats advance.
  always_comb begin
    rcon_d = rcon_q;
    if (clear) begin
      rcon_d = '0;
    end else if (init) begin
      rcon_d = RCON_INIT;
    end else if (advance) begin
      rcon_d = xtime8(rcon_q);
    end
  end

  // rcon register, async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcon_q <= '0;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: load handshake, round/rcon stepping,
// result handshake and register-bank clock-gate enable.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NR        = NR_AES128,
  parameter int unsigned IDLE_HOLD = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       sel_init,
  output logic       round_en,
  output logic       kexp_en,
  output logic       last_round,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       cg_en
);

  localparam logic [3:0] NR_L      = 4'(NR);
  localparam logic [3:0] LAST_FULL = 4'(NR - 1);
  localparam logic [3:0] HOLD_INIT = 4'(IDLE_HOLD);

  aes_ctrl_state_t state_q, state_d;
  logic [3:0]      round_q, round_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            rc_init, rc_adv, rc_clr;

  aes_rcon_gen u_rcon (
    .clk     (clk),
    .rst     (rst),
    .init    (rc_init),
    .advance (rc_adv),
    .clear   (rc_clr),
    .rcon    (rcon)
  );

  // Next-state, round counter, idle-hold counter and output decode.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    cnt_d      = cnt_q;
    ld_ready   = 1'b0;
    sel_init   = 1'b0;
    round_en   = 1'b0;
    kexp_en    = 1'b0;
    last_round = 1'b0;
    out_valid  = 1'b0;
    cg_en      = 1'b1;
    rc_init    = 1'b0;
    rc_adv     = 1'b0;
    rc_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ld_ready = !flush;
        sel_init = 1'b1;
        cg_en    = ld_valid | (cnt_q != '0);
        if (ld_valid && !flush) begin
          round_en = 1'b1;
          kexp_en  = 1'b1;
          rc_init  = 1'b1;
          cnt_d    = '0;
          if (NR > 1) begin
            state_d = ST_ROUND;
            round_d = 4'd1;
          end else begin
            state_d = ST_FINAL;
            round_d = NR_L;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ROUND: begin
        round_en = 1'b1;
        kexp_en  = 1'b1;
        rc_adv   = 1'b1;
        round_d  = round_q + 4'd1;
        if (round_q == LAST_FULL) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        round_en   = 1'b1;
        kexp_en    = 1'b1;
        last_round = 1'b1;
        rc_clr     = 1'b1;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
          round_d = '0;
          cnt_d   = HOLD_INIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        round_d = '0;
      end
    endcase

    // Abort overrides every transition; only an actual entry into IDLE
    // reloads the idle-hold counter.
    if (flush) begin
      state_d = ST_IDLE;
      round_d = '0;
      rc_clr  = 1'b1;
      if (state_q != ST_IDLE) begin
        cnt_d = HOLD_INIT;
      end
    end
  end

  // State, round and idle-hold registers, async active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
    end
  end

  assign round = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: NR=10 and NR=14 instances share stimulus and are
// checked every cycle against a transaction-level model.
module tb_aes_round_ctrl;

  localparam int unsigned HOLD_CYC = 2;

  logic clk = 1'b0;
  logic rst, flush, ld_valid, out_ready;

  logic       w_ldr[2], w_ov[2], w_sel[2], w_ren[2], w_ken[2], w_last[2], w_cg[2];
  logic [3:0] w_round[2];
  logic [7:0] w_rcon[2];

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10), .IDLE_HOLD(HOLD_CYC)) dut10 (
    .clk(clk), .rst(rst), .flush(flush), .ld_valid(ld_valid), .ld_ready(w_ldr[0]),
    .out_ready(out_ready), .out_valid(w_ov[0]), .sel_init(w_sel[0]), .round_en(w_ren[0]),
    .kexp_en(w_ken[0]), .last_round(w_last[0]), .round(w_round[0]), .rcon(w_rcon[0]),
    .cg_en(w_cg[0])
  );

  aes_round_ctrl #(.NR(14), .IDLE_HOLD(HOLD_CYC)) dut14 (
    .clk(clk), .rst(rst), .flush(flush), .ld_valid(ld_valid), .ld_ready(w_ldr[1]),
    .out_ready(out_ready), .out_valid(w_ov[1]), .sel_init(w_sel[1]), .round_en(w_ren[1]),
    .kexp_en(w_ken[1]), .last_round(w_last[1]), .round(w_round[1]), .rcon(w_rcon[1]),
    .cg_en(w_cg[1])
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: busy flag, cycles since the load handshake, idle-hold countdown.
  int  nr_m[2] = '{10, 14};
  bit  busy_m[2];
  int  k_m[2];
  int  cnt_m[2];
  byte unsigned rcon_tab[15] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                 8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      busy_m[i] = 1'b0;
      k_m[i]    = 0;
      cnt_m[i]  = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (flush) begin
        if (busy_m[i]) cnt_m[i] = HOLD_CYC;
        else if (cnt_m[i] > 0) cnt_m[i] = cnt_m[i] - 1;
        busy_m[i] = 1'b0;
        k_m[i]    = 0;
      end else if (!busy_m[i]) begin
        if (ld_valid) begin
          busy_m[i] = 1'b1;
          k_m[i]    = 1;
          cnt_m[i]  = 0;
        end else if (cnt_m[i] > 0) begin
          cnt_m[i] = cnt_m[i] - 1;
        end
      end else if (k_m[i] <= nr_m[i]) begin
        k_m[i] = k_m[i] + 1;
      end else if (out_ready) begin
        busy_m[i] = 1'b0;
        k_m[i]    = 0;
        cnt_m[i]  = HOLD_CYC;
      end
    end
  endtask

  task automatic compare_all();
    logic       e_ldr, e_sel, e_en, e_last, e_ov, e_cg;
    logic [3:0] e_round;
    logic [7:0] e_rcon;
    bit         do_round;
    for (int i = 0; i < 2; i++) begin
      do_round = 1'b1;
      if (!busy_m[i]) begin
        e_ldr = !flush; e_sel = 1'b1; e_en = ld_valid && !flush; e_last = 1'b0;
        e_ov = 1'b0; e_cg = ld_valid || (cnt_m[i] > 0); e_round = 4'd0; e_rcon = 8'h00;
      end else if (k_m[i] <= nr_m[i]) begin
        e_ldr = 1'b0; e_sel = 1'b0; e_en = 1'b1; e_last = (k_m[i] == nr_m[i]);
        e_ov = 1'b0; e_cg = 1'b1; e_round = 4'(k_m[i]); e_rcon = rcon_tab[k_m[i]];
      end else begin
        e_ldr = 1'b0; e_sel = 1'b0; e_en = 1'b0; e_last = 1'b0;
        e_ov = 1'b1; e_cg = 1'b1; e_round = 4'd0; e_rcon = 8'h00; do_round = 1'b0;
      end
      chk($sformatf("ld_ready[nr%0d]", nr_m[i]), 32'(w_ldr[i]), 32'(e_ldr));
      chk($sformatf("sel_init[nr%0d]", nr_m[i]), 32'(w_sel[i]), 32'(e_sel));
      chk($sformatf("round_en[nr%0d]", nr_m[i]), 32'(w_ren[i]), 32'(e_en));
      chk($sformatf("kexp_en[nr%0d]", nr_m[i]), 32'(w_ken[i]), 32'(e_en));
      chk($sformatf("last_round[nr%0d]", nr_m[i]), 32'(w_last[i]), 32'(e_last));
      chk($sformatf("out_valid[nr%0d]", nr_m[i]), 32'(w_ov[i]), 32'(e_ov));
      chk($sformatf("cg_en[nr%0d]", nr_m[i]), 32'(w_cg[i]), 32'(e_cg));
      chk($sformatf("rcon[nr%0d]", nr_m[i]), 32'(w_rcon[i]), 32'(e_rcon));
      if (do_round) chk($sformatf("round[nr%0d]", nr_m[i]), 32'(w_round[i]), 32'(e_round));
    end
  endtask

  // One clock: update model at the edge, then apply the next inputs and check.
  task automatic cyc(input logic lv, input logic fl, input logic ordy);
    @(posedge clk);
    model_edge();
    #1;
    ld_valid  = lv;
    flush     = fl;
    out_ready = ordy;
    #1;
    compare_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat0, lat1, ov_cnt0;
    rst = 1'b0; flush = 1'b0; ld_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    #2 compare_all();

    // Release reset and load at the very first edge.
    #1 rst = 1'b1; ld_valid = 1'b1; out_ready = 1'b1;
    #1 compare_all();

    lat0 = -1; lat1 = -1; ov_cnt0 = 0;
    for (int c = 1; c <= 24; c++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (w_ov[0]) ov_cnt0++;
      if (w_ov[0] && lat0 < 0) lat0 = c;
      if (w_ov[1] && lat1 < 0) lat1 = c;
    end
    chk("latency_nr10", 32'(lat0), 32'd11);
    chk("latency_nr14", 32'(lat1), 32'd15);
    chk("ov_pulse_nr10", 32'(ov_cnt0), 32'd1);

    // Raise ld_valid from a gated-off idle, then reset mid-ROUND at round 5.
    cyc(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 20 && k_m[0] != 5; c++) cyc(1'b0, 1'b0, 1'b1);
    chk("reached_round5", 32'(w_round[0]), 32'd5);
    #1 rst = 1'b0; ld_valid = 1'b0;
    model_reset();
    #1 compare_all();
    #1 rst = 1'b1; ld_valid = 1'b1;
    #1 compare_all();

    // Load accepted at the first edge after release, then back-pressure.
    for (int c = 0; c < 31; c++) cyc(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) cyc(1'b0, 1'b0, 1'b1);

    // Flush at round 4 with ld_valid held through and after the flush.
    cyc(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 20 && k_m[0] != 3; c++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("restart_round1", 32'(w_round[0]), 32'd1);
    for (int c = 0; c < 20; c++) cyc(1'b0, 1'b0, 1'b1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0),
          1'($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencing controller for the iterative AES cipher datapath in `aes_cipher_top`. It accepts a load request, steps the shared state/key-expansion registers through the initial AddRoundKey, NR-1 full rounds and one final round, and presents the result with a valid/ready handshake. It also drives the clock-gate enable for the register bank on the cipher clock-tree leaves, so that bank idles when no block is in flight.

## Interface
- NR, 10, number of cipher rounds; legal values 10, 12, 14.
- IDLE_HOLD, 2, cycles `cg_en` stays high after returning to IDLE; legal range 0..15.
- clk  in  1  cipher clock; the only clock in the block.
- rst  in  1  reset; asynchronous assert, active-low.
- flush  in  1  synchronous abort.
- ld_valid  in  1  load request; text and key are valid on the datapath inputs.
- ld_ready  out  1  controller accepts a load.
- out_ready  in  1  consumer accepts the result.
- out_valid  out  1  `text_out` register holds a finished block.
- sel_init  out  1  datapath mux selects text^key (initial AddRoundKey).
- round_en  out  1  state register load enable.
- kexp_en  out  1  key-expansion register load enable.
- last_round  out  1  final round; the datapath bypasses MixColumns.
- round  out  4  current round index, 0..NR.
- rcon  out  8  round constant for the current round.
- cg_en  out  1  enable for the register-bank ICG.

## Operation
- States: IDLE, ROUND, FINAL, HOLD.
- **IDLE**
  - `ld_ready`=1 and `sel_init`=1; `round`=0.
  - When `ld_valid`&`ld_ready` (handshake): `round_en`=`kexp_en`=1 and the datapath captures text^key.
  - Next state is ROUND with `round`=1 if NR>1; otherwise FINAL.
- **ROUND**
  - `round_en`=`kexp_en`=1.
  - `round` increments each cycle.
  - When `round`==NR-1, the next state is FINAL.
- **FINAL**
  - `round`=NR, `last_round`=1, `round_en`=`kexp_en`=1.
  - Next state is HOLD.
- **HOLD**
  - `out_valid`=1; all load enables are 0, so the state register holds.
  - When `out_valid`&`out_ready`, the next state is IDLE.
- **rcon**
  - `rcon`=0x01 in round 1.
  - Each round advances it by xtime: left shift, XOR with 0x1B if bit 7 was set. The round 1..10 sequence is 01,02,04,08,10,20,40,80,1B,36; it continues as xtime for rounds 11..14.
  - `rcon`=0x00 in IDLE and HOLD.
- **cg_en**
  - `cg_en`=1 in ROUND, FINAL and HOLD, and combinationally in IDLE whenever `ld_valid`=1.
  - On entry to IDLE, a 4-bit down-counter loads IDLE_HOLD. `cg_en` stays 1 while the counter is nonzero.
- **flush**
  - `flush` forces IDLE at the next edge from any state.
  - Clears `out_valid` and the round and rcon registers; `cg_en` follows the IDLE rule.
  - `ld_ready` is 0 in any cycle where `flush`=1, so `flush` beats a simultaneous `ld_valid`.
- No pipelining: only one block is in flight. `ld_ready` is 0 outside IDLE.

## Timing
- Reset values (async, while `rst`=0):
  - State IDLE; `round`=0, `rcon`=0x00, `out_valid`=0.
  - `ld_ready`=1 and `sel_init`=1 (IDLE decode).
  - `round_en`=`kexp_en`=`last_round`=0.
  - `cg_en`=0; the IDLE_HOLD counter is 0.
- Reset deassertion is synchronized externally. The first edge after deassertion may accept a load.
- Latency:
  - Handshake edge is cycle 0; round r executes at cycle r.
  - `out_valid` rises at cycle NR+1: 11 for AES-128.
- Throughput: HOLD lasts at least one cycle before returning to IDLE, so the minimum load-to-load spacing is NR+2 cycles.
- `out_valid` is registered and stays high until accepted. `out_ready` asserted early has no effect.
- `ld_ready`, `sel_init`, `round_en`, `kexp_en` and `cg_en` are Moore decodes of registered state. The only exceptions are the IDLE-state `ld_valid` and `flush` terms, which are combinational.

## Structure
- Package `aes_ctrl_pkg` holds:
  - the state enum `aes_ctrl_state_t`;
  - `NR_AES128`/`NR_AES192`/`NR_AES256` = 10/12/14;
  - function `xtime8`;
  - `RCON_INIT`=8'h01.
- One sub-module, `aes_rcon_gen`: an 8-bit rcon register with `init`/`advance`/`clear` controls and the xtime update.
- FSM, round counter and `cg_en` hold counter live in `aes_round_ctrl`.

## Test plan
- Reset mid-ROUND, at `round`=5 → all outputs immediately at their reset values; a load at the first edge after release is accepted.
- Single load, NR=10, `out_ready`=1 → `out_valid` at cycle 11 for exactly one cycle, `round` 1..10, `rcon` 01,02,04,08,10,20,40,80,1B,36, `last_round` only at cycle 10.
- Back-pressure: `out_ready`=0 for 20 cycles after `out_valid` → `out_valid` held, `round_en`=0, `ld_ready`=0; IDLE one edge after `out_ready`=1.
- `flush` at `round`=4, with `ld_valid`=1 in the same and following cycles → IDLE next edge, `out_valid` never asserts, load accepted the cycle after `flush` drops, new `round` restarts at 1.
- IDLE_HOLD=2: after acceptance, `cg_en` high 2 cycles in IDLE then low. Raising `ld_valid` while `cg_en`=0 → `cg_en`=1 in that same cycle.
- NR=14 → `out_valid` at cycle 15, `rcon` at round 11..14 = 6C,D8,AB,4D.
